// File: rtl/nios_keys_pkg.sv
// Shared constants and helpers for the push-button debounce block.
package nios_keys_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

    // Counter width able to hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One debounce channel: two-flop synchronizer, stability counter, accepted
// level and registered press/release pulses.
module key_debounce_bit
    import nios_keys_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          IDLE_PIN = ACTIVE_LOW;

    logic [1:0]    sync_q;
    logic          sync;
    logic [CW-1:0] cnt;
    db_state_e     state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= {2{IDLE_PIN}};
        else          sync_q <= {sync_q[0], key_raw};
    end

    // Polarity is normalised after the second flop: sync is 1 while pressed.
    assign sync = sync_q[1] ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_STABLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            case (state)
                ST_STABLE: begin
                    if (sync != level) begin
                        state <= ST_PENDING;
                        cnt   <= CW'(1);
                    end
                end
                ST_PENDING: begin
                    if (sync == level) begin
                        // Bounce back to the accepted level aborts the change.
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                        level <= ~level;
                        press <= ~level;
                        rel   <= level;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// WIDTH independent push-button debouncers; keys_level feeds the key PIO directly.
module key_debounce
    import nios_keys_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] keys_level,
    output logic [WIDTH-1:0] keys_press,
    output logic [WIDTH-1:0] keys_release
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        key_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .key_raw (key_raw[i]),
            .level   (keys_level[i]),
            .press   (keys_press[i]),
            .rel     (keys_release[i])
        );
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter WIDTH, default 4: number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable clk cycles needed to accept a level change (1 ms at 50 MHz); legal range 2..2^20.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means raw key pin low = pressed.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 key_raw  input  WIDTH  asynchronous, bouncing key pins from the board.
REQ-007 keys_level  output  WIDTH  debounced level, active-high (1 = pressed); drives the key PIO in_port.
REQ-008 keys_press  output  WIDTH  one-cycle pulse per channel on accepted press.
REQ-009 keys_release  output  WIDTH  one-cycle pulse per channel on accepted release.

Function
REQ-010 Each key_raw bit SHALL pass through a two-flop synchronizer before any other logic; polarity is normalised after the second flop (inverted when ACTIVE_LOW=1), giving sync[i], active-high.
REQ-011 Each channel SHALL hold a registered stable bit (the keys_level bit) and a saturating counter of width clog2(DEBOUNCE_CYCLES).
REQ-012 Per-channel state machine, two states: STABLE (sync == stable, counter = 0) and PENDING (sync != stable, counter counting).
REQ-013 STABLE -> PENDING when sync != stable; the counter increments to 1 on that edge.
REQ-014 PENDING -> STABLE with counter cleared and stable unchanged, whenever sync == stable (bounce aborts the change).
REQ-015 In PENDING, once the counter equals DEBOUNCE_CYCLES-1 and sync != stable still holds, on the next edge: stable toggles, counter clears, and the state returns to STABLE.
REQ-016 Accepted-change latency SHALL be exactly 2 (synchronizer) + DEBOUNCE_CYCLES clk cycles from the first edge that samples the new raw level, provided the raw level holds throughout.
REQ-017 keys_press[i] SHALL be 1 for exactly the one cycle in which keys_level[i] has just risen; keys_release[i] likewise for a fall; both are registered and never high together on one channel.
REQ-018 A raw pulse or glitch shorter than DEBOUNCE_CYCLES sampled cycles SHALL produce no change on any output.
REQ-019 Channels SHALL be fully independent; simultaneous changes on several channels give simultaneous pulses.
REQ-020 The counter SHALL never wrap; with a legal DEBOUNCE_CYCLES it cannot exceed DEBOUNCE_CYCLES-1.

Reset
REQ-021 On reset_n low, immediately and asynchronously: synchronizer flops = released level (1 if ACTIVE_LOW else 0), stable = 0, counters = 0, keys_level = keys_press = keys_release = 0.
REQ-022 Reset asserted mid-PENDING SHALL discard the pending change; no pulse is emitted after release.
REQ-023 A key held during reset SHALL be accepted as a press 2+DEBOUNCE_CYCLES cycles after reset_n deasserts, with one keys_press pulse.

Structure
REQ-024 The default DEBOUNCE_CYCLES and the shared counter-width function SHALL live in package nios_keys_pkg.
REQ-025 One sub-module key_debounce_bit (synchronizer, counter, stable bit, pulse flops for a single channel) SHALL be instantiated WIDTH times by a generate loop.
REQ-026 There SHALL be no bus interface; keys_level connects directly to the PIO in_port.

Verification (DEBOUNCE_CYCLES=8, WIDTH=4, ACTIVE_LOW=1)
REQ-027 Reset with key_raw=4'hF -> all outputs 0; no pulses for 100 cycles.
REQ-028 key_raw[0] 1->0 held -> keys_level[0]=1 and a one-cycle keys_press[0] exactly 10 cycles after the first sampling edge; release gives keys_release[0] 10 cycles later.
REQ-029 key_raw[1] low for 7 cycles then high -> no output change; repeat 5 such bursts then hold low -> press accepted 10 cycles after the final fall.
REQ-030 key_raw 4'hF -> 4'h0 on one edge -> keys_level 4'hF and keys_press 4'hF in the same cycle.
REQ-031 reset_n pulsed low 5 cycles into a pending press on key 2 -> no pulse; key still held -> press accepted 10 cycles after reset release.
REQ-032 Random bounce (1-7 cycle glitches) on all keys for 10k cycles -> each accepted change matches a reference model; press/release counts alternate per key.
